// File: rtl/adc_scan_scheduler.sv
// ADC scan scheduler: shares one ADC request/result channel between periodic channel
// sweeps and priority host one-shots, keeps a latest-value table and flags timeouts.
module adc_scan_scheduler #(
  parameter int          NUM_CH   = 8,
  parameter int          TIMEOUT  = 1023,
  parameter logic [7:0]  SCAN_TAG = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] cfg_data,
  input  logic        cfg_wr,
  input  logic [7:0]  req_addr,
  input  logic        req_wr,
  output logic        req_busy,
  output logic [23:0] adc_in_data,
  output logic        adc_in_wr,
  input  logic [23:0] adc_out_data,
  input  logic        adc_out_wr,
  output logic [23:0] out_data,
  output logic        out_wr,
  input  logic [2:0]  rd_ch,
  output logic [9:0]  rd_data,
  output logic [3:0]  status
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [15:0]        period_q, period_d;
  logic [15:0]        per_cnt_q, per_cnt_d;
  logic [NUM_CH-1:0]  sweep_mask_q, sweep_mask_d;
  logic               busy_q, busy_d;
  logic [7:0]         req_tag_q, req_tag_d;
  logic [7:0]         cur_tag_q, cur_tag_d;
  logic               cur_oneshot_q, cur_oneshot_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [23:0]        adc_in_data_q, adc_in_data_d;
  logic               adc_in_wr_q, adc_in_wr_d;
  logic [23:0]        out_data_q, out_data_d;
  logic               out_wr_q, out_wr_d;
  logic [2:0]         status_q, status_d;
  logic [9:0]         res_tab_q [NUM_CH];
  logic [9:0]         res_tab_d [NUM_CH];
  logic [9:0]         rd_data_q, rd_data_d;

  logic               tick;
  logic               clr_cmd;
  logic               scan_hit;
  logic [CH_W-1:0]    scan_ch;
  logic               unused_adc_hi;

  // The result tag is tracked locally, so the echoed upper result bits are not needed.
  assign unused_adc_hi = ^adc_out_data[23:10];

  // A write of period 0xFFFF with an empty mask is a status-clear command, not a config load.
  assign clr_cmd = cfg_wr && (cfg_data[23:8] == 16'hFFFF) && (cfg_data[7:0] == 8'h00);

  always_comb begin
    scan_hit = 1'b0;
    scan_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (sweep_mask_q[i]) begin
        scan_hit = 1'b1;
        scan_ch  = CH_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the branches infers a latch.
    state_d       = state_q;
    mask_d        = mask_q;
    period_d      = period_q;
    per_cnt_d     = per_cnt_q;
    sweep_mask_d  = sweep_mask_q;
    busy_d        = busy_q;
    req_tag_d     = req_tag_q;
    cur_tag_d     = cur_tag_q;
    cur_oneshot_d = cur_oneshot_q;
    to_cnt_d      = to_cnt_q;
    adc_in_data_d = adc_in_data_q;
    adc_in_wr_d   = 1'b0;
    out_data_d    = out_data_q;
    out_wr_d      = 1'b0;
    status_d      = status_q;
    res_tab_d     = res_tab_q;
    rd_data_d     = res_tab_q[rd_ch[CH_W-1:0]];
    tick          = 1'b0;

    if (clr_cmd) status_d = '0;

    if (cfg_wr && !clr_cmd) begin
      mask_d    = cfg_data[NUM_CH-1:0];
      period_d  = cfg_data[23:8];
      per_cnt_d = cfg_data[23:8];
    end else if (period_q != 16'd0) begin
      if (per_cnt_q <= 16'd1) begin
        tick      = 1'b1;
        per_cnt_d = period_q;
      end else begin
        per_cnt_d = per_cnt_q - 16'd1;
      end
    end

    // A new sweep starts only once the previous one has fully drained.
    if (tick && (mask_q != '0)) begin
      if (sweep_mask_q == '0) sweep_mask_d = mask_q;
      else                    status_d[0]  = 1'b1;
    end

    if (req_wr) begin
      if (busy_q) begin
        status_d[2] = 1'b1;
      end else begin
        busy_d    = 1'b1;
        req_tag_d = req_addr;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (busy_q || scan_hit) begin
          if (busy_q) begin
            cur_tag_d     = req_tag_q;
            cur_oneshot_d = 1'b1;
          end else begin
            cur_tag_d             = SCAN_TAG | 8'(scan_ch);
            cur_oneshot_d         = 1'b0;
            sweep_mask_d[scan_ch] = 1'b0;
          end
          adc_in_data_d = {16'b0, cur_tag_d};
          adc_in_wr_d   = 1'b1;
          to_cnt_d      = '0;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (adc_out_wr) begin
          out_data_d = {cur_tag_q, 6'b0, adc_out_data[9:0]};
          out_wr_d   = 1'b1;
          state_d    = ST_IDLE;
          if (cur_oneshot_q) busy_d = 1'b0;
          else               res_tab_d[cur_tag_q[CH_W-1:0]] = adc_out_data[9:0];
        end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
          out_data_d  = {cur_tag_q, 6'b100000, 10'h3FF};
          out_wr_d    = 1'b1;
          status_d[1] = 1'b1;
          state_d     = ST_IDLE;
          if (cur_oneshot_q) busy_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      period_q      <= '0;
      per_cnt_q     <= '0;
      sweep_mask_q  <= '0;
      busy_q        <= 1'b0;
      req_tag_q     <= '0;
      cur_tag_q     <= '0;
      cur_oneshot_q <= 1'b0;
      to_cnt_q      <= '0;
      adc_in_data_q <= '0;
      adc_in_wr_q   <= 1'b0;
      out_data_q    <= '0;
      out_wr_q      <= 1'b0;
      status_q      <= '0;
      rd_data_q     <= '0;
      // NOTE: the result table is small and must read back zero after reset, so it is built from resettable flops.
      for (int i = 0; i < NUM_CH; i++) res_tab_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      period_q      <= period_d;
      per_cnt_q     <= per_cnt_d;
      sweep_mask_q  <= sweep_mask_d;
      busy_q        <= busy_d;
      req_tag_q     <= req_tag_d;
      cur_tag_q     <= cur_tag_d;
      cur_oneshot_q <= cur_oneshot_d;
      to_cnt_q      <= to_cnt_d;
      adc_in_data_q <= adc_in_data_d;
      adc_in_wr_q   <= adc_in_wr_d;
      out_data_q    <= out_data_d;
      out_wr_q      <= out_wr_d;
      status_q      <= status_d;
      rd_data_q     <= rd_data_d;
      for (int i = 0; i < NUM_CH; i++) res_tab_q[i] <= res_tab_d[i];
    end
  end

  assign req_busy    = busy_q;
  assign adc_in_data = adc_in_data_q;
  assign adc_in_wr   = adc_in_wr_q;
  assign out_data    = out_data_q;
  assign out_wr      = out_wr_q;
  assign rd_data     = rd_data_q;
  assign status      = {1'b0, status_q};

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Self-checking bench for adc_scan_scheduler: table-driven one-shots plus directed
// sweep, priority, drop, timeout, overrun and reset-mid-conversion sequences.
module tb_adc_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] cfg_data;
  logic        cfg_wr;
  logic [7:0]  req_addr;
  logic        req_wr;
  logic        req_busy;
  logic [23:0] adc_in_data;
  logic        adc_in_wr;
  logic [23:0] adc_out_data;
  logic        adc_out_wr;
  logic [23:0] out_data;
  logic        out_wr;
  logic [2:0]  rd_ch;
  logic [9:0]  rd_data;
  logic [3:0]  status;

  adc_scan_scheduler dut (
    .clk(clk), .rst(rst),
    .cfg_data(cfg_data), .cfg_wr(cfg_wr),
    .req_addr(req_addr), .req_wr(req_wr), .req_busy(req_busy),
    .adc_in_data(adc_in_data), .adc_in_wr(adc_in_wr),
    .adc_out_data(adc_out_data), .adc_out_wr(adc_out_wr),
    .out_data(out_data), .out_wr(out_wr),
    .rd_ch(rd_ch), .rd_data(rd_data), .status(status)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]  issue_q[$];
  logic [23:0] out_q[$];
  logic        busy_at_out_q[$];
  int          adc_lat = 0;

  // ADC model and monitor: answers each request after adc_lat cycles (0 = never)
  // with data 10'h155 + channel, and logs every issue and every host result.
  initial begin
    int          rsp_cnt;
    logic [23:0] rsp_word;
    rsp_cnt      = 0;
    rsp_word     = '0;
    adc_out_wr   = 1'b0;
    adc_out_data = '0;
    forever begin
      @(negedge clk);
      adc_out_wr = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          adc_out_data = rsp_word;
          adc_out_wr   = 1'b1;
        end
      end
      if (adc_in_wr === 1'b1) begin
        issue_q.push_back(adc_in_data[7:0]);
        if (adc_lat > 0) begin
          rsp_cnt  = adc_lat;
          rsp_word = {adc_in_data[7:0], 6'b0, 10'h155 + {7'b0, adc_in_data[2:0]}};
        end
      end
      if (out_wr === 1'b1) begin
        out_q.push_back(out_data);
        busy_at_out_q.push_back(req_busy);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] issue_at(input int i);
    return (i < issue_q.size()) ? issue_q[i] : 8'hxx;
  endfunction

  function automatic logic [23:0] out_at(input int i);
    return (i < out_q.size()) ? out_q[i] : 24'hxxxxxx;
  endfunction

  function automatic logic busy_at(input int i);
    return (i < busy_at_out_q.size()) ? busy_at_out_q[i] : 1'bx;
  endfunction

  task automatic wait_issue(input int target, input int budget, input string name);
    int k = 0;
    while (issue_q.size() < target && k < budget) begin step(); k++; end
    if (issue_q.size() < target) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: issue count %0d after %0d cycles, expected %0d", name, issue_q.size(), budget, target);
    end
  endtask

  task automatic wait_out(input int target, input int budget, input string name);
    int k = 0;
    while (out_q.size() < target && k < budget) begin step(); k++; end
    if (out_q.size() < target) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: result count %0d after %0d cycles, expected %0d", name, out_q.size(), budget, target);
    end
  endtask

  task automatic write_cfg(input logic [23:0] d);
    cfg_data = d;
    cfg_wr   = 1'b1;
    step();
    cfg_wr   = 1'b0;
  endtask

  task automatic read_tab(input logic [2:0] ch, input logic [9:0] exp, input string name);
    rd_ch = ch;
    step();
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic clear_logs();
    issue_q.delete();
    out_q.delete();
    busy_at_out_q.delete();
  endtask

  typedef struct {
    logic [7:0]  addr;
    int          lat;
    logic [23:0] exp_out;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   sz;
    int   k;

    vecs[0] = '{8'h13, 5,  24'h130158};
    vecs[1] = '{8'h05, 1,  24'h05015A};
    vecs[2] = '{8'hFF, 40, 24'hFF015C};
    vecs[3] = '{8'h80, 12, 24'h800155};

    rst = 1'b1; cfg_data = '0; cfg_wr = 1'b0; req_addr = '0; req_wr = 1'b0; rd_ch = '0;

    // Reset then idle
    step(); step();
    rst = 1'b0;
    step();
    check("rst_adc_in_wr",   32'(adc_in_wr),   32'd0);
    check("rst_adc_in_data", 32'(adc_in_data), 32'd0);
    check("rst_out_wr",      32'(out_wr),      32'd0);
    check("rst_out_data",    32'(out_data),    32'd0);
    check("rst_req_busy",    32'(req_busy),    32'd0);
    check("rst_rd_data",     32'(rd_data),     32'd0);
    check("rst_status",      32'(status),      32'd0);
    repeat (1000) step();
    check("idle_no_issue", 32'(issue_q.size()), 32'd0);
    check("idle_no_out",   32'(out_q.size()),   32'd0);

    // One-shot vectors with sweeps off
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      adc_lat  = vecs[i].lat;
      req_addr = vecs[i].addr;
      req_wr   = 1'b1;
      step();
      req_wr   = 1'b0;
      check($sformatf("os%0d_busy_set", i), 32'(req_busy), 32'd1);
      wait_out(1, vecs[i].lat + 20, $sformatf("os%0d_wait", i));
      repeat (3) step();
      check($sformatf("os%0d_tag", i),        32'(issue_at(0)),   32'(vecs[i].addr));
      check($sformatf("os%0d_out", i),        32'(out_at(0)),     32'(vecs[i].exp_out));
      check($sformatf("os%0d_busy_at_out", i), 32'(busy_at(0)),   32'd0);
      check($sformatf("os%0d_one_result", i), 32'(out_q.size()),  32'd1);
    end
    read_tab(3'd3, 10'h000, "os_tab3_untouched");
    read_tab(3'd0, 10'h000, "os_tab0_untouched");

    // Sweep of channels 0 and 2, period 500, ADC latency 180
    clear_logs();
    adc_lat = 180;
    write_cfg({16'd500, 8'b0000_0101});
    repeat (495) step();
    check("sweep_quiet_before_tick", 32'(issue_q.size()), 32'd0);
    wait_issue(1, 20, "sweep_first_issue");
    wait_out(2, 600, "sweep_results");
    write_cfg(24'h000000);
    check("sweep_tag0", 32'(issue_at(0)), 32'h80);
    check("sweep_tag1", 32'(issue_at(1)), 32'h82);
    check("sweep_out0", 32'(out_at(0)),   32'h800155);
    check("sweep_out1", 32'(out_at(1)),   32'h820157);
    read_tab(3'd2, 10'h157, "sweep_tab2");
    read_tab(3'd0, 10'h155, "sweep_tab0");
    read_tab(3'd1, 10'h000, "sweep_tab1_disabled");
    check("sweep_status", 32'(status), 32'd0);

    // One-shot on the same cycle as the sweep tick wins
    clear_logs();
    adc_lat = 20;
    write_cfg({16'd60, 8'h01});
    repeat (59) step();
    req_addr = 8'h13;
    req_wr   = 1'b1;
    step();
    req_wr   = 1'b0;
    check("prio_busy_set", 32'(req_busy), 32'd1);
    wait_out(2, 100, "prio_results");
    write_cfg(24'h000000);
    check("prio_first_tag",   32'(issue_at(0)), 32'h13);
    check("prio_second_tag",  32'(issue_at(1)), 32'h80);
    check("prio_out0",        32'(out_at(0)),   32'h130158);
    check("prio_busy_at_out", 32'(busy_at(0)),  32'd0);
    check("prio_out1",        32'(out_at(1)),   32'h800155);

    // Second request while busy is dropped
    clear_logs();
    adc_lat  = 30;
    req_addr = 8'h21;
    req_wr   = 1'b1;
    step();
    req_wr   = 1'b0;
    step(); step();
    req_addr = 8'h22;
    req_wr   = 1'b1;
    step();
    req_wr   = 1'b0;
    wait_out(1, 60, "drop_result");
    repeat (60) step();
    check("drop_one_result", 32'(out_q.size()),   32'd1);
    check("drop_one_issue",  32'(issue_q.size()), 32'd1);
    check("drop_out",        32'(out_at(0)),      32'h210156);
    check("drop_status",     32'(status),         32'b0100);
    write_cfg(24'hFFFF00);
    check("clear_status", 32'(status), 32'd0);
    repeat (100) step();
    check("clear_keeps_cfg", 32'(issue_q.size()), 32'd1);

    // ADC never answers: both sweep channels time out in turn
    clear_logs();
    adc_lat = 0;
    write_cfg({16'd3000, 8'h03});
    wait_issue(1, 3100, "to_first_issue");
    check("to_tag0", 32'(issue_at(0)), 32'h80);
    repeat (1000) step();
    check("to_quiet_before_limit", 32'(out_q.size()), 32'd0);
    wait_out(1, 60, "to_first_result");
    check("to_out0",    32'(out_at(0)), 32'h8083FF);
    check("to_status",  32'(status),    32'b0010);
    wait_issue(2, 10, "to_next_issue");
    check("to_tag1", 32'(issue_at(1)), 32'h81);
    wait_out(2, 1100, "to_second_result");
    write_cfg(24'h000000);
    check("to_out1", 32'(out_at(1)), 32'h8183FF);
    read_tab(3'd0, 10'h155, "to_tab0_unchanged");
    read_tab(3'd1, 10'h000, "to_tab1_unchanged");

    // Overrun, then reset while a conversion is outstanding
    write_cfg(24'hFFFF00);
    clear_logs();
    adc_lat = 180;
    write_cfg({16'd100, 8'h03});
    k = 0;
    while (status[0] !== 1'b1 && k < 400) begin step(); k++; end
    check("ovr_status0", 32'(status[0]), 32'd1);
    sz = issue_q.size();
    wait_issue(sz + 1, 400, "ovr_fresh_issue");
    repeat (10) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    sz = issue_q.size();
    k  = out_q.size();
    repeat (250) step();
    check("rstmid_no_out",    32'(out_q.size()),   32'(k));
    check("rstmid_no_issue",  32'(issue_q.size()), 32'(sz));
    check("rstmid_status",    32'(status),         32'd0);
    check("rstmid_req_busy",  32'(req_busy),       32'd0);
    check("rstmid_out_data",  32'(out_data),       32'd0);
    read_tab(3'd0, 10'h000, "rstmid_tab0");
    read_tab(3'd1, 10'h000, "rstmid_tab1");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
